pll_reset_seq: RTL and testbench
================================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 12, giving the number of cycles the PLL is held in reset per attempt.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 1200000, giving the maximum number of cycles to wait for lock before retrying.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 12000, giving the number of consecutive locked cycles required before release.
REQ-004 The block SHALL have port clk, input, 1 bit: the single free-running clock (the 12 MHz reference); all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-007 The block SHALL have port pll_resetb, output, 1 bit: drives PLL RESETB, active-low.
REQ-008 The block SHALL have port sys_reset, output, 1 bit: active-high reset for the PLL-clocked logic.
REQ-009 The block SHALL have port ready, output, 1 bit: high while the PLL is locked and stable.
REQ-010 The block SHALL have port lock_lost, output, 1 bit: a one-cycle pulse on loss of lock while running.
REQ-011 The block SHALL have port retry_count, output, 8 bits: number of lock timeouts, saturating.

Function
REQ-012 pll_lock SHALL pass through a 2-flop synchronizer; lock_s (2nd flop) is the only lock value used; lock_s lags pll_lock by 2 cycles.
REQ-013 One shared 24-bit cycle counter SHALL be cleared on every state change and incremented otherwise; parameters SHALL be in [1, 2^24-1].
REQ-014 States SHALL be PLLRST, WAIT, STABLE, RUN; all outputs SHALL be registered and change on the same edge as the state register.
REQ-015 PLLRST: pll_resetb=0; after RESET_CYCLES cycles in the state (counter == RESET_CYCLES-1) the next state SHALL be WAIT.
REQ-016 WAIT: pll_resetb=1; lock_s=1 SHALL go to STABLE; otherwise, when counter == LOCK_TIMEOUT-1, it SHALL go to PLLRST and increment retry_count, saturating at 255.
REQ-017 When lock_s=1 and timeout coincide in WAIT, lock SHALL win: go to STABLE and leave retry_count unchanged.
REQ-018 STABLE: pll_resetb=1; lock_s=0 SHALL return to WAIT with no retry increment; when counter == STABLE_CYCLES-1 with lock_s=1 it SHALL go to RUN.
REQ-019 RUN: pll_resetb=1, sys_reset=0, ready=1; lock_s=0 SHALL go to PLLRST and pulse lock_lost for exactly one cycle.
REQ-020 sys_reset SHALL be 1 and ready SHALL be 0 in every state except RUN.
REQ-021 retry_count SHALL never clear except on reset.

Reset
REQ-022 While reset=1: state=PLLRST, counter=0, synchronizer flops=0, pll_resetb=0, sys_reset=1, ready=0, lock_lost=0, retry_count=0.
REQ-023 Reset asserted in any state, including mid-RUN, SHALL take effect on the next edge with no lock_lost pulse.

Verification (RESET_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8)
REQ-024 Clean lock: pll_lock=1 throughout, reset released at edge 0 -> pll_resetb=0 for edges 0-3; WAIT at edge 4; STABLE at edge 5; ready=1 and sys_reset=0 from edge 13.
REQ-025 No lock: pll_lock=0 -> repeating pattern of 4 cycles with pll_resetb=0 then 16 cycles with pll_resetb=1; retry_count increments every 20 cycles and holds at 255.
REQ-026 Glitch in STABLE: lock drops for 1 cycle midway -> state returns to WAIT; the full 8 stable cycles are required again; retry_count is unchanged; ready is never high early.
REQ-027 Loss in RUN: pll_lock falls -> 2 cycles later the block goes to PLLRST, lock_lost=1 for 1 cycle, sys_reset=1, ready=0, pll_resetb=0; it relocks following the REQ-024 timing.
REQ-028 Simultaneous events: lock_s rises on the last WAIT timeout cycle -> STABLE is entered and retry_count is not incremented.
REQ-029 Reset mid-RUN: reset=1 for 1 cycle -> all REQ-022 values next edge, retry_count=0, lock_lost stays 0.

Source files
------------

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Brings up a PLL from the free-running reference clock and produces a clean
// reset for the logic the PLL clocks. The sequencer holds the PLL in reset
// for a fixed time, then waits (with a timeout) for LOCK. Once LOCK is seen,
// LOCK must stay high for a number of consecutive cycles before sys_reset is
// released. Losing lock while running restarts the whole sequence and raises
// a one-cycle lock_lost pulse. Lock timeouts are counted in retry_count,
// which saturates at 255.
//
// Ports
//   clk          in   reference clock; everything runs on its rising edge
//   reset        in   synchronous, active-high
//   pll_lock     in   PLL LOCK, asynchronous to clk
//   pll_resetb   out  PLL RESETB, active-low
//   sys_reset    out  active-high reset for the PLL-clocked logic
//   ready        out  high while the PLL is locked and stable
//   lock_lost    out  one-cycle pulse when lock drops while running
//   retry_count  out  number of lock timeouts, saturating at 255
//
// All parameters must lie in [1, 2^24-1].
// -----------------------------------------------------------------------------
module pll_reset_seq #(
  parameter int unsigned RESET_CYCLES  = 12,
  parameter int unsigned LOCK_TIMEOUT  = 1200000,
  parameter int unsigned STABLE_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  typedef enum logic [1:0] {
    S_PLLRST = 2'd0,
    S_WAIT   = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  // Terminal counts: the counter holds the number of cycles already spent in
  // the current state, so a state lasting N cycles leaves when it reads N-1.
  localparam logic [23:0] C_RST_LAST    = 24'(RESET_CYCLES - 1);
  localparam logic [23:0] C_TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] C_STABLE_LAST = 24'(STABLE_CYCLES - 1);

  state_t      r_state;
  logic [23:0] r_count;
  logic        r_lock_meta;
  logic        r_lock_s;
  logic [7:0]  r_retry;
  logic        r_pll_resetb;
  logic        r_sys_reset;
  logic        r_ready;
  logic        r_lock_lost;

  state_t      w_state_next;
  logic [7:0]  w_retry_next;
  logic        w_lock_lost_next;

  // Next-state decision. Only the synchronized lock_s is ever looked at.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave it unassigned (no latch).
    w_state_next     = r_state;
    w_retry_next     = r_retry;
    w_lock_lost_next = 1'b0;
    unique case (r_state)
      S_PLLRST: begin
        if (r_count == C_RST_LAST) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // Lock is tested first, so a lock arriving on the timeout cycle wins
        // and the retry counter is left alone.
        if (r_lock_s) begin
          w_state_next = S_STABLE;
        end else if (r_count == C_TIMEOUT_LAST) begin
          w_state_next = S_PLLRST;
          if (r_retry != 8'hFF) w_retry_next = r_retry + 8'd1;
        end
      end
      S_STABLE: begin
        if (!r_lock_s) begin
          w_state_next = S_WAIT;
        end else if (r_count == C_STABLE_LAST) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_state_next     = S_PLLRST;
          w_lock_lost_next = 1'b1;
        end
      end
      default: w_state_next = S_PLLRST;
    endcase
  end

  // State, counter, synchronizer and registered outputs. Outputs are decoded
  // from the next state so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (reset) begin
      r_state      <= S_PLLRST;
      r_count      <= '0;
      r_lock_meta  <= 1'b0;
      r_lock_s     <= 1'b0;
      r_retry      <= '0;
      r_pll_resetb <= 1'b0;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      // Two-flop synchronizer for the asynchronous LOCK input.
      r_lock_meta  <= pll_lock;
      r_lock_s     <= r_lock_meta;

      r_state      <= w_state_next;
      r_count      <= (w_state_next != r_state) ? 24'd0 : r_count + 24'd1;
      r_retry      <= w_retry_next;
      r_pll_resetb <= (w_state_next != S_PLLRST);
      r_sys_reset  <= (w_state_next != S_RUN);
      r_ready      <= (w_state_next == S_RUN);
      r_lock_lost  <= w_lock_lost_next;
    end
  end

  assign pll_resetb  = r_pll_resetb;
  assign sys_reset   = r_sys_reset;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Drives pll_reset_seq with short parameters (4 / 16 / 8). A behavioural
// model runs beside the DUT and every output is compared on every cycle after
// the first reset edge. Directed scenarios add hand-computed expectations at
// specific edges (edge 0 = the last edge with reset high), followed by a
// randomized lock/reset stimulus phase.
// -----------------------------------------------------------------------------
module tb_pll_reset_seq;

  localparam int RC = 4;
  localparam int LT = 16;
  localparam int SC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .pll_resetb (pll_resetb),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: which phase of bring-up we are in, when it began, and
  // the lock value the sequencer is allowed to see (pll_lock two edges ago).
  // ---------------------------------------------------------------------------
  typedef enum {M_HOLD, M_LISTEN, M_SETTLE, M_LIVE} mphase_t;

  mphase_t m_phase;
  int      m_now;
  int      m_entered;
  int      m_retries;
  bit      m_lost;
  bit      m_valid = 1'b0;
  bit      m_seen[$];

  always @(posedge clk) begin : model
    bit      seen;
    int      spent;
    mphase_t nxt;
    if (reset) begin
      m_phase   = M_HOLD;
      m_now     = 0;
      m_entered = 0;
      m_retries = 0;
      m_lost    = 1'b0;
      m_seen    = {1'b0, 1'b0};
      m_valid   = 1'b1;
    end else if (m_valid) begin
      m_now++;
      seen   = m_seen.pop_front();
      m_seen.push_back(pll_lock);
      spent  = m_now - m_entered;  // cycles in this phase, counting this edge
      nxt    = m_phase;
      m_lost = 1'b0;
      case (m_phase)
        M_HOLD:   if (spent == RC) nxt = M_LISTEN;
        M_LISTEN: begin
          if (seen) nxt = M_SETTLE;
          else if (spent == LT) begin
            nxt = M_HOLD;
            m_retries = (m_retries < 255) ? m_retries + 1 : 255;
          end
        end
        M_SETTLE: begin
          if (!seen) nxt = M_LISTEN;
          else if (spent == SC) nxt = M_LIVE;
        end
        M_LIVE: if (!seen) begin nxt = M_HOLD; m_lost = 1'b1; end
      endcase
      if (nxt != m_phase) m_entered = m_now;
      m_phase = nxt;
    end
    if (m_valid) begin
      #1;
      check("model_pll_resetb", pll_resetb, m_phase != M_HOLD);
      check("model_sys_reset", sys_reset, m_phase != M_LIVE);
      check("model_ready", ready, m_phase == M_LIVE);
      check("model_lock_lost", lock_lost, m_lost);
      check("model_retry_count", retry_count, m_retries);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change only on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Edge 0 is the edge that samples reset=1; returns between edges 0 and 1.
  task automatic do_reset(input logic lock);
    @(negedge clk);
    reset    = 1'b1;
    pll_lock = lock;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      edges(1);
      n++;
    end
    check(name, ready, 1'b1);
  endtask

  initial begin
    // Clean lock: PLL reset for edges 0-3, WAIT at 4, STABLE at 5, RUN at 13.
    do_reset(1'b1);
    edges(3);  check("clean_resetb_e3", pll_resetb, 1'b0);
    edges(1);  check("clean_resetb_e4", pll_resetb, 1'b1);
    edges(8);  check("clean_ready_e12", ready, 1'b0);
    edges(1);  check("clean_ready_e13", ready, 1'b1);
               check("clean_sysrst_e13", sys_reset, 1'b0);

    // Loss in RUN: lock falls before edge 14, lock_s sees it at edge 15,
    // PLLRST and lock_lost at edge 16; relock reaches RUN 13 edges later.
    @(negedge clk); pll_lock = 1'b0;
    edges(2);  check("loss_ready_e15", ready, 1'b1);
    edges(1);  check("loss_lost_e16", lock_lost, 1'b1);
               check("loss_ready_e16", ready, 1'b0);
               check("loss_resetb_e16", pll_resetb, 1'b0);
               check("loss_sysrst_e16", sys_reset, 1'b1);
    @(negedge clk); pll_lock = 1'b1;
    edges(1);  check("loss_lost_e17", lock_lost, 1'b0);
    edges(11); check("relock_ready_e28", ready, 1'b0);
    edges(1);  check("relock_ready_e29", ready, 1'b1);

    // Glitch in STABLE: low before edge 8 only -> WAIT at 10, STABLE at 11,
    // RUN at 19 instead of 13.
    do_reset(1'b1);
    edges(7);
    @(negedge clk); pll_lock = 1'b0;
    @(negedge clk); pll_lock = 1'b1;
    edges(10); check("glitch_ready_e18", ready, 1'b0);
    edges(1);  check("glitch_ready_e19", ready, 1'b1);
               check("glitch_retry", retry_count, 8'd0);

    // Lock arrives exactly on the timeout cycle (edge 20): lock wins.
    do_reset(1'b0);
    edges(17);
    @(negedge clk); pll_lock = 1'b1;
    edges(2);  check("simul_resetb_e19", pll_resetb, 1'b1);
    edges(1);  check("simul_resetb_e20", pll_resetb, 1'b1);
               check("simul_retry_e20", retry_count, 8'd0);
    edges(7);  check("simul_ready_e27", ready, 1'b0);
    edges(1);  check("simul_ready_e28", ready, 1'b1);

    // No lock: 20-cycle retry period, saturating at 255.
    do_reset(1'b0);
    edges(19); check("nolock_retry_e19", retry_count, 8'd0);
               check("nolock_resetb_e19", pll_resetb, 1'b1);
    edges(1);  check("nolock_retry_e20", retry_count, 8'd1);
               check("nolock_resetb_e20", pll_resetb, 1'b0);
    edges(20); check("nolock_retry_e40", retry_count, 8'd2);
    edges(20 * 260);
               check("nolock_retry_sat", retry_count, 8'd255);

    // Relock keeps the count; then reset while running, with lock falling so
    // that a loss would otherwise be detected on the reset edge.
    @(negedge clk); pll_lock = 1'b1;
    wait_ready(100, "sat_relock_ready");
    check("sat_retry_kept", retry_count, 8'd255);
    @(negedge clk); pll_lock = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    edges(1);
    check("rst_run_lost", lock_lost, 1'b0);
    check("rst_run_ready", ready, 1'b0);
    check("rst_run_sysrst", sys_reset, 1'b1);
    check("rst_run_resetb", pll_resetb, 1'b0);
    check("rst_run_retry", retry_count, 8'd0);
    @(negedge clk); reset = 1'b0;

    // Randomized lock behaviour and occasional resets, checked by the model.
    for (int seg = 0; seg < 60; seg++) begin
      int mode = $urandom_range(0, 4);
      int len;
      case (mode)
        0: begin  // long stretch of steady lock
          len = $urandom_range(10, 60);
          for (int i = 0; i < len; i++) begin @(negedge clk); pll_lock = 1'b1; end
        end
        1: begin  // no lock
          len = $urandom_range(10, 70);
          for (int i = 0; i < len; i++) begin @(negedge clk); pll_lock = 1'b0; end
        end
        2: begin  // noisy lock
          len = $urandom_range(10, 60);
          for (int i = 0; i < len; i++) begin
            @(negedge clk); pll_lock = ($urandom_range(0, 3) != 0);
          end
        end
        3: begin  // short dropouts
          len = $urandom_range(1, 3);
          for (int i = 0; i < len; i++) begin @(negedge clk); pll_lock = 1'b0; end
          @(negedge clk); pll_lock = 1'b1;
        end
        default: begin  // reset pulse
          @(negedge clk); reset = 1'b1; pll_lock = $urandom_range(0, 1);
          @(negedge clk); reset = 1'b0;
        end
      endcase
    end
    edges(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
